bram_port_arbiter: RTL and testbench
====================================

# bram_port_arbiter

Two-port round-robin arbiter sharing one 32-bit byte-addressable BRAM array between the core's data port (port 0) and instruction-fetch port (port 1). Issues at most one access per cycle to the array, routes the one-cycle-later read data and acknowledge back to the issuing port, and rejects misaligned or out-of-range accesses with an error response without touching memory. Sits between the pipeline's memory stages and the BRAM array.

## Interface
- SIZE_BYTE, 8192, array capacity in bytes; addresses >= SIZE_BYTE are out of range.
- i_clk  in  1  clock; all state updates on rising edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_pN_req  in  1  port N (N=0,1) request valid.
- i_pN_we  in  1  port N write (1) / read (0).
- i_pN_mask_type  in  2  00 byte, 01 halfword, 10 word, 11 illegal.
- i_pN_addr  in  32  port N byte address.
- i_pN_data  in  32  port N write data (right-aligned).
- o_pN_gnt  out  1  port N request accepted this cycle.
- o_pN_ack  out  1  response for port N's accepted request.
- o_pN_err  out  1  accepted request was rejected; valid with o_pN_ack.
- o_pN_data  out  32  read data; valid with o_pN_ack.
- o_mem_en, o_mem_we  out  1  array enable / write enable.
- o_mem_mask_type  out  2  to array.
- o_mem_addr, o_mem_data  out  32  to array.
- i_mem_data  in  32  array read data (one cycle after o_mem_en).
- i_mem_ack  in  1  array acknowledge (one cycle after o_mem_en).

## Operation
- Handshake: request accepted in cycle N iff i_pN_req & o_pN_gnt. Requester holds fields stable until granted; may present a new request in the cycle after grant.
- Grant (combinational from req and priority register): one requester → granted; both → port not granted most recently; none → no grant. Grants forced 0 while i_rst_n low.
- Priority register last_gnt: reset 1 (so port 0 wins first conflict); updates to the granted port on every grant, including rejected ones.
- Legality check on granted request: illegal if mask_type=11, halfword with addr[0]=1, word with addr[1:0]!=00, or addr >= SIZE_BYTE.
- Legal grant: o_mem_en=1, o_mem_we/mask_type/addr/data = granted port's fields, same cycle. Illegal or no grant: o_mem_en=0, o_mem_we=0, other mem outputs 0.
- Response registers (reset 0): rsp_valid, rsp_port, rsp_err, loaded each cycle from the grant.
- Response cycle: o_pN_ack = rsp_valid & rsp_port==N & (rsp_err | i_mem_ack). o_pN_err = o_pN_ack & rsp_err. o_pN_data = i_mem_data when o_pN_ack & ~rsp_err & read, else 0.
- Non-responding port: ack, err, data all 0.
- Missing i_mem_ack on a legal issue: no ack to requester; response lost (array is fixed-latency, treated as unreachable).

## Timing
- Reset values: all o_pN_* 0, all o_mem_* 0, last_gnt=1, rsp_valid=0.
- Grant and memory issue: combinational, 0 cycles.
- Response latency: exactly 1 cycle after grant, for both legal and rejected requests.
- Throughput: one access per cycle; back-to-back grants from the same port allowed when the other is idle.
- Simultaneous: both ports requesting every cycle → strict alternation 0,1,0,1 from reset.
- Response in cycle N+1 and new grant in N+1 coexist; response registers reloaded in the same edge.
- Reset asserted mid-operation: pending response discarded, no ack after reset release; first post-reset cycle has all outputs 0 until a request arrives.

## Test plan
- Single port 0 word write addr 0x10 data 0xDEADBEEF, then read 0x10 → gnt same cycle, ack next cycle, read returns 0xDEADBEEF, o_p1_* stay 0.
- Both ports request reads continuously from reset → grants alternate p0,p1,p0,p1; each ack arrives to the correct port one cycle after its grant.
- Port 1 halfword read addr 0x3, port 0 idle → gnt, o_mem_en=0, next cycle o_p1_ack=1, o_p1_err=1, o_p1_data=0.
- Port 0 byte read addr 0x2000 (SIZE_BYTE=8192) → rejected with err; mask_type 11 at addr 0 → rejected with err.
- Port 0 byte write 0xAB to 0x5, port 1 byte read 0x5 the next cycle → read returns 0x000000AB.
- Assert i_rst_n low in the cycle after a grant → no ack emitted; after release, both ports requesting → port 0 granted first.

Source files
------------

// File: rtl/bram_port_arbiter.sv
// Two-port round-robin arbiter in front of a single fixed-latency BRAM array.
// Illegal (misaligned / out-of-range / bad size) requests are answered with an error without touching memory.
module bram_port_arbiter #(
  parameter int unsigned SIZE_BYTE = 8192
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_p0_req,
  input  logic        i_p0_we,
  input  logic [1:0]  i_p0_mask_type,
  input  logic [31:0] i_p0_addr,
  input  logic [31:0] i_p0_data,
  output logic        o_p0_gnt,
  output logic        o_p0_ack,
  output logic        o_p0_err,
  output logic [31:0] o_p0_data,
  input  logic        i_p1_req,
  input  logic        i_p1_we,
  input  logic [1:0]  i_p1_mask_type,
  input  logic [31:0] i_p1_addr,
  input  logic [31:0] i_p1_data,
  output logic        o_p1_gnt,
  output logic        o_p1_ack,
  output logic        o_p1_err,
  output logic [31:0] o_p1_data,
  output logic        o_mem_en,
  output logic        o_mem_we,
  output logic [1:0]  o_mem_mask_type,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_data,
  input  logic [31:0] i_mem_data,
  input  logic        i_mem_ack
);

  function automatic logic is_legal(input logic [1:0] mask_type, input logic [31:0] addr);
    logic aligned;
    case (mask_type)
      2'b00:   aligned = 1'b1;
      2'b01:   aligned = ~addr[0];
      2'b10:   aligned = (addr[1:0] == 2'b00);
      default: aligned = 1'b0;
    endcase
    return aligned && (addr < 32'(SIZE_BYTE));
  endfunction

  logic        last_gnt_q, last_gnt_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_port_q, rsp_port_d;
  logic        rsp_err_q, rsp_err_d;
  logic        rsp_we_q, rsp_we_d;
  logic        gnt0, gnt1, any_gnt, legal;
  logic        sel_we;
  logic [1:0]  sel_mask_type;
  logic [31:0] sel_addr, sel_data;

  // Round-robin grant: on conflict the port not granted last time wins.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!i_rst_n) begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
    end else if (i_p0_req && i_p1_req) begin
      gnt0 = last_gnt_q;
      gnt1 = ~last_gnt_q;
    end else begin
      gnt0 = i_p0_req;
      gnt1 = i_p1_req;
    end
  end

  // Select the granted port's fields and issue to the array only if legal.
  always_comb begin
    any_gnt         = gnt0 | gnt1;
    sel_we          = gnt1 ? i_p1_we        : i_p0_we;
    sel_mask_type   = gnt1 ? i_p1_mask_type : i_p0_mask_type;
    sel_addr        = gnt1 ? i_p1_addr      : i_p0_addr;
    sel_data        = gnt1 ? i_p1_data      : i_p0_data;
    legal           = any_gnt & is_legal(sel_mask_type, sel_addr);
    o_mem_en        = 1'b0;
    o_mem_we        = 1'b0;
    o_mem_mask_type = 2'b00;
    o_mem_addr      = 32'h0000_0000;
    o_mem_data      = 32'h0000_0000;
    if (legal) begin
      o_mem_en        = 1'b1;
      o_mem_we        = sel_we;
      o_mem_mask_type = sel_mask_type;
      o_mem_addr      = sel_addr;
      o_mem_data      = sel_data;
    end else begin
      o_mem_en        = 1'b0;
    end
  end

  // Next-state for priority and response tracking; rejected grants still count.
  always_comb begin
    last_gnt_d  = any_gnt ? gnt1 : last_gnt_q;
    rsp_valid_d = any_gnt;
    rsp_port_d  = gnt1;
    rsp_err_d   = any_gnt & ~legal;
    rsp_we_d    = any_gnt & sel_we;
  end

  // Priority and response registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      last_gnt_q  <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_port_q  <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_we_q    <= 1'b0;
    end else begin
      last_gnt_q  <= last_gnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_port_q  <= rsp_port_d;
      rsp_err_q   <= rsp_err_d;
      rsp_we_q    <= rsp_we_d;
    end
  end

  // Route the response to the port that issued; a missing array ack drops a legal response.
  always_comb begin
    o_p0_gnt  = gnt0;
    o_p1_gnt  = gnt1;
    o_p0_ack  = rsp_valid_q & ~rsp_port_q & (rsp_err_q | i_mem_ack);
    o_p1_ack  = rsp_valid_q &  rsp_port_q & (rsp_err_q | i_mem_ack);
    o_p0_err  = o_p0_ack & rsp_err_q;
    o_p1_err  = o_p1_ack & rsp_err_q;
    o_p0_data = (o_p0_ack && !rsp_err_q && !rsp_we_q) ? i_mem_data : 32'h0000_0000;
    o_p1_data = (o_p1_ack && !rsp_err_q && !rsp_we_q) ? i_mem_data : 32'h0000_0000;
  end

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Directed bench for bram_port_arbiter with a small one-cycle-latency BRAM model.
module tb_bram_port_arbiter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        p0_req = 1'b0, p0_we = 1'b0, p1_req = 1'b0, p1_we = 1'b0;
  logic [1:0]  p0_mt = 2'b00, p1_mt = 2'b00;
  logic [31:0] p0_addr = 32'h0, p0_wdata = 32'h0, p1_addr = 32'h0, p1_wdata = 32'h0;
  logic        p0_gnt, p0_ack, p0_err, p1_gnt, p1_ack, p1_err;
  logic [31:0] p0_rdata, p1_rdata;
  logic        mem_en, mem_we;
  logic [1:0]  mem_mt;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = 32'h0;
  logic        mem_ack = 1'b0;
  logic [31:0] mem [0:2047];
  int checks = 0;
  int failures = 0;

  bram_port_arbiter #(.SIZE_BYTE(8192)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_p0_req(p0_req), .i_p0_we(p0_we), .i_p0_mask_type(p0_mt), .i_p0_addr(p0_addr), .i_p0_data(p0_wdata),
    .o_p0_gnt(p0_gnt), .o_p0_ack(p0_ack), .o_p0_err(p0_err), .o_p0_data(p0_rdata),
    .i_p1_req(p1_req), .i_p1_we(p1_we), .i_p1_mask_type(p1_mt), .i_p1_addr(p1_addr), .i_p1_data(p1_wdata),
    .o_p1_gnt(p1_gnt), .o_p1_ack(p1_ack), .o_p1_err(p1_err), .o_p1_data(p1_rdata),
    .o_mem_en(mem_en), .o_mem_we(mem_we), .o_mem_mask_type(mem_mt), .o_mem_addr(mem_addr),
    .o_mem_data(mem_wdata), .i_mem_data(mem_rdata), .i_mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  // Byte-addressable array model: writes land in lanes, reads return right-aligned zero-extended data.
  always @(posedge clk) begin
    mem_ack <= mem_en;
    if (mem_en) begin
      if (mem_we) begin
        case (mem_mt)
          2'b00:   mem[mem_addr[12:2]][{mem_addr[1:0], 3'b000} +: 8] <= mem_wdata[7:0];
          2'b01:   mem[mem_addr[12:2]][{mem_addr[1], 4'b0000} +: 16] <= mem_wdata[15:0];
          default: mem[mem_addr[12:2]] <= mem_wdata;
        endcase
        mem_rdata <= 32'h0;
      end else begin
        case (mem_mt)
          2'b00:   mem_rdata <= (mem[mem_addr[12:2]] >> {mem_addr[1:0], 3'b000}) & 32'h0000_00FF;
          2'b01:   mem_rdata <= (mem[mem_addr[12:2]] >> {mem_addr[1], 4'b0000}) & 32'h0000_FFFF;
          default: mem_rdata <= mem[mem_addr[12:2]];
        endcase
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    p0_req = 1'b0; p0_we = 1'b0; p0_mt = 2'b00; p0_addr = 32'h0; p0_wdata = 32'h0;
    p1_req = 1'b0; p1_we = 1'b0; p1_mt = 2'b00; p1_addr = 32'h0; p1_wdata = 32'h0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    p0_req = 1'b1; p1_req = 1'b1; p0_mt = 2'b10; p1_mt = 2'b10;
    #3;
    checks++; if ({p0_gnt, p1_gnt} !== 2'b00) begin failures++; $display("FAIL reset_gnt got=%b exp=00", {p0_gnt, p1_gnt}); end
    checks++; if ({mem_en, mem_we, mem_mt, mem_addr, mem_wdata} !== 68'h0) begin failures++; $display("FAIL reset_mem got en=%b addr=%h", mem_en, mem_addr); end
    checks++; if ({p0_ack, p0_err, p0_rdata, p1_ack, p1_err, p1_rdata} !== 68'h0) begin failures++; $display("FAIL reset_rsp got ack0=%b ack1=%b", p0_ack, p1_ack); end
    idle();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_word_rw();
    p0_req = 1'b1; p0_we = 1'b1; p0_mt = 2'b10; p0_addr = 32'h10; p0_wdata = 32'hDEAD_BEEF;
    #3;
    checks++; if ({p0_gnt, p1_gnt} !== 2'b10) begin failures++; $display("FAIL wr_gnt got=%b exp=10", {p0_gnt, p1_gnt}); end
    checks++; if ({mem_en, mem_we, mem_mt, mem_addr, mem_wdata} !== {1'b1, 1'b1, 2'b10, 32'h10, 32'hDEAD_BEEF}) begin failures++; $display("FAIL wr_issue got en=%b we=%b addr=%h data=%h", mem_en, mem_we, mem_addr, mem_wdata); end
    tick();
    p0_we = 1'b0; p0_wdata = 32'h0;
    checks++; if ({p0_ack, p0_err, p0_rdata} !== {1'b1, 1'b0, 32'h0}) begin failures++; $display("FAIL wr_ack got ack=%b err=%b data=%h exp ack=1 err=0 data=0", p0_ack, p0_err, p0_rdata); end
    #3;
    checks++; if ({p0_gnt, mem_en, mem_we} !== 3'b110) begin failures++; $display("FAIL rd_issue got gnt=%b en=%b we=%b", p0_gnt, mem_en, mem_we); end
    tick();
    idle();
    checks++; if ({p0_ack, p0_err, p0_rdata} !== {1'b1, 1'b0, 32'hDEAD_BEEF}) begin failures++; $display("FAIL rd_data got ack=%b err=%b data=%h exp=deadbeef", p0_ack, p0_err, p0_rdata); end
    checks++; if ({p1_gnt, p1_ack, p1_err, p1_rdata} !== 35'h0) begin failures++; $display("FAIL p1_quiet got ack=%b data=%h", p1_ack, p1_rdata); end
    tick();
  endtask

  task automatic test_alternate();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    p0_req = 1'b1; p0_mt = 2'b10; p0_addr = 32'h10;
    p1_req = 1'b1; p1_mt = 2'b10; p1_addr = 32'h10;
    for (int i = 0; i < 4; i++) begin
      #3;
      checks++; if ({p0_gnt, p1_gnt} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin failures++; $display("FAIL alt_gnt[%0d] got=%b", i, {p0_gnt, p1_gnt}); end
      tick();
      if (i % 2 == 0) begin
        checks++; if ({p0_ack, p1_ack, p0_rdata} !== {2'b10, 32'hDEAD_BEEF}) begin failures++; $display("FAIL alt_ack[%0d] got ack=%b%b data=%h exp ack0", i, p0_ack, p1_ack, p0_rdata); end
      end else begin
        checks++; if ({p0_ack, p1_ack, p1_rdata} !== {2'b01, 32'hDEAD_BEEF}) begin failures++; $display("FAIL alt_ack[%0d] got ack=%b%b data=%h exp ack1", i, p0_ack, p1_ack, p1_rdata); end
      end
    end
    idle();
    tick();
  endtask

  task automatic test_illegal();
    p1_req = 1'b1; p1_mt = 2'b01; p1_addr = 32'h3;
    #3;
    checks++; if ({p1_gnt, mem_en, mem_addr} !== {2'b10, 32'h0}) begin failures++; $display("FAIL hw_mis_issue got gnt=%b en=%b addr=%h", p1_gnt, mem_en, mem_addr); end
    tick();
    idle();
    checks++; if ({p1_ack, p1_err, p1_rdata, p0_ack} !== {2'b11, 32'h0, 1'b0}) begin failures++; $display("FAIL hw_mis_rsp got ack=%b err=%b data=%h", p1_ack, p1_err, p1_rdata); end
    p0_req = 1'b1; p0_mt = 2'b00; p0_addr = 32'h2000;
    #3;
    checks++; if ({p0_gnt, mem_en} !== 2'b10) begin failures++; $display("FAIL oor_issue got gnt=%b en=%b", p0_gnt, mem_en); end
    tick();
    p0_mt = 2'b11; p0_addr = 32'h0;
    checks++; if ({p0_ack, p0_err, p0_rdata} !== {2'b11, 32'h0}) begin failures++; $display("FAIL oor_rsp got ack=%b err=%b data=%h", p0_ack, p0_err, p0_rdata); end
    #3;
    checks++; if ({p0_gnt, mem_en} !== 2'b10) begin failures++; $display("FAIL mt11_issue got gnt=%b en=%b", p0_gnt, mem_en); end
    tick();
    idle();
    checks++; if ({p0_ack, p0_err} !== 2'b11) begin failures++; $display("FAIL mt11_rsp got ack=%b err=%b", p0_ack, p0_err); end
    tick();
  endtask

  task automatic test_back_to_back();
    p0_req = 1'b1; p0_we = 1'b1; p0_mt = 2'b00; p0_addr = 32'h5; p0_wdata = 32'h0000_00AB;
    #3;
    checks++; if ({p0_gnt, mem_en, mem_mt, mem_addr} !== {2'b11, 2'b00, 32'h5}) begin failures++; $display("FAIL bwr_issue got gnt=%b en=%b addr=%h", p0_gnt, mem_en, mem_addr); end
    tick();
    idle();
    p1_req = 1'b1; p1_mt = 2'b00; p1_addr = 32'h5;
    checks++; if ({p0_ack, p0_err} !== 2'b10) begin failures++; $display("FAIL bwr_ack got ack=%b err=%b", p0_ack, p0_err); end
    #3;
    checks++; if ({p1_gnt, mem_en, mem_we} !== 3'b110) begin failures++; $display("FAIL brd_issue got gnt=%b en=%b we=%b", p1_gnt, mem_en, mem_we); end
    tick();
    idle();
    checks++; if ({p1_ack, p1_err, p1_rdata} !== {2'b10, 32'h0000_00AB}) begin failures++; $display("FAIL brd_data got ack=%b err=%b data=%h exp=000000ab", p1_ack, p1_err, p1_rdata); end
    tick();
  endtask

  task automatic test_reset_mid();
    p1_req = 1'b1; p1_mt = 2'b10; p1_addr = 32'h10;
    #3;
    checks++; if (p1_gnt !== 1'b1) begin failures++; $display("FAIL rm_gnt got=%b exp=1", p1_gnt); end
    tick();
    rst_n = 1'b0;
    idle();
    #1;
    checks++; if ({p0_ack, p1_ack, p1_rdata} !== 34'h0) begin failures++; $display("FAIL rm_noack got ack=%b%b data=%h", p0_ack, p1_ack, p1_rdata); end
    tick();
    rst_n = 1'b1;
    #1;
    checks++; if ({p0_ack, p1_ack, p0_gnt, p1_gnt, mem_en} !== 5'b0) begin failures++; $display("FAIL rm_quiet got ack=%b%b gnt=%b%b en=%b", p0_ack, p1_ack, p0_gnt, p1_gnt, mem_en); end
    p0_req = 1'b1; p0_mt = 2'b10; p0_addr = 32'h10;
    p1_req = 1'b1; p1_mt = 2'b10; p1_addr = 32'h10;
    #2;
    checks++; if ({p0_gnt, p1_gnt} !== 2'b10) begin failures++; $display("FAIL rm_first_gnt got=%b exp=10", {p0_gnt, p1_gnt}); end
    tick();
    idle();
    checks++; if ({p0_ack, p1_ack, p0_rdata} !== {2'b10, 32'hDEAD_BEEF}) begin failures++; $display("FAIL rm_ack got ack=%b%b data=%h", p0_ack, p1_ack, p0_rdata); end
    tick();
  endtask

  initial begin
    #1;
    test_reset();
    test_word_rw();
    test_alternate();
    test_illegal();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
